// File: rtl/tc_frame_scheduler.sv
// Telecommand frame scheduler: round-robin arbitration over frame sources, word-by-word
// delivery to the TC serializer, completion wait, watchdog and inter-frame gap.
module tc_frame_scheduler #(
  parameter int NUM_REQ         = 2,
  parameter int WORDS_PER_FRAME = 10,
  parameter int GAP_CYCLES      = 64,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [3:0]            rd_addr,
  input  logic [32*NUM_REQ-1:0] rd_data,
  output logic [31:0]           ser_data,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  input  logic                  ser_done,
  output logic                  tc_start,
  input  logic                  abort,
  output logic [NUM_REQ-1:0]    frame_done,
  output logic                  timeout_err,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW    = $clog2(GAP_CYCLES + 1);
  localparam int WW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_FETCH, S_PUSH, S_DRAIN, S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
  logic [3:0]         rd_addr_q, rd_addr_d;
  logic [3:0]         word_cnt_q, word_cnt_d;
  logic [31:0]        ser_data_q, ser_data_d;
  logic               ser_valid_q, ser_valid_d;
  logic               tc_start_q, tc_start_d;
  logic [NUM_REQ-1:0] frame_done_q, frame_done_d;
  logic               timeout_err_q, timeout_err_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [WW-1:0]      wd_cnt_q, wd_cnt_d;

  logic               found;
  logic [IDX_W-1:0]   pick, cand;
  logic               abort_hit, timeout_hit;

  // Word handshake: ser_data is transferred on a rising edge where ser_valid and ser_ready
  // are both high; ser_valid and ser_data hold steady until then, and ser_ready alone does nothing.
  always_comb begin
    found = 1'b0;
    pick  = last_gnt_q;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_gnt_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign abort_hit   = abort && (state_q inside {S_ARB, S_FETCH, S_PUSH, S_DRAIN});
  assign timeout_hit = (wd_cnt_q == WW'(TIMEOUT_CYCLES - 1)) &&
                       (((state_q == S_PUSH) && !ser_ready) || ((state_q == S_DRAIN) && !ser_done));

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_gnt_d    = last_gnt_q;
    rd_addr_d     = rd_addr_q;
    word_cnt_d    = word_cnt_q;
    ser_data_d    = ser_data_q;
    ser_valid_d   = ser_valid_q;
    tc_start_d    = tc_start_q;
    frame_done_d  = '0;
    timeout_err_d = 1'b0;
    gap_cnt_d     = gap_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    case (state_q)
      S_IDLE: if (|req) state_d = S_ARB;
      S_ARB: begin
        if (found) begin
          gnt_d      = NUM_REQ'(1) << pick;
          last_gnt_d = pick;
          rd_addr_d  = '0;
          word_cnt_d = '0;
          tc_start_d = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        ser_data_d  = rd_data[32*last_gnt_q +: 32];
        ser_valid_d = 1'b1;
        wd_cnt_d    = '0;
        state_d     = S_PUSH;
      end
      S_PUSH: begin
        if (ser_ready) begin
          ser_valid_d = 1'b0;
          wd_cnt_d    = '0;
          if (word_cnt_q == 4'(WORDS_PER_FRAME - 1)) begin
            state_d = S_DRAIN;
          end else begin
            word_cnt_d = word_cnt_q + 4'd1;
            rd_addr_d  = rd_addr_q + 4'd1;
            state_d    = S_FETCH;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + WW'(1);
        end
      end
      S_DRAIN: begin
        if (ser_done) begin
          frame_done_d = gnt_q;
          tc_start_d   = 1'b0;
          gnt_d        = '0;
          gap_cnt_d    = '0;
          wd_cnt_d     = '0;
          state_d      = S_GAP;
        end else begin
          wd_cnt_d = wd_cnt_q + WW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Abort and watchdog expiry share one teardown path; it overrides any same-cycle progress.
    if (abort_hit || timeout_hit) begin
      last_gnt_d   = last_gnt_q;
      ser_valid_d  = 1'b0;
      tc_start_d   = 1'b0;
      gnt_d        = '0;
      frame_done_d = '0;
      gap_cnt_d    = '0;
      wd_cnt_d     = '0;
      state_d      = S_GAP;
    end
    timeout_err_d = timeout_hit;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      gnt_q         <= '0;
      last_gnt_q    <= IDX_W'(NUM_REQ - 1);
      rd_addr_q     <= '0;
      word_cnt_q    <= '0;
      ser_data_q    <= '0;
      ser_valid_q   <= 1'b0;
      tc_start_q    <= 1'b0;
      frame_done_q  <= '0;
      timeout_err_q <= 1'b0;
      gap_cnt_q     <= '0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_gnt_q    <= last_gnt_d;
      rd_addr_q     <= rd_addr_d;
      word_cnt_q    <= word_cnt_d;
      ser_data_q    <= ser_data_d;
      ser_valid_q   <= ser_valid_d;
      tc_start_q    <= tc_start_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      gap_cnt_q     <= gap_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign rd_addr     = rd_addr_q;
  assign ser_data    = ser_data_q;
  assign ser_valid   = ser_valid_q;
  assign tc_start    = tc_start_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tc_frame_scheduler.sv
// Directed bench for tc_frame_scheduler: two sources with distinct word patterns and a
// small serializer model that accepts words, optionally stalls, and pulses ser_done.
module tb_tc_frame_scheduler;

  localparam int WPF = 10;
  localparam logic [2:0] S_IDLE = 3'd0, S_ARB = 3'd1, S_PUSH = 3'd3, S_DRAIN = 3'd4, S_GAP = 3'd5;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  gnt;
  logic [3:0]  rd_addr;
  logic [63:0] rd_data;
  logic [31:0] ser_data;
  logic        ser_valid;
  logic        ser_ready = 1'b1;
  logic        ser_done = 1'b0;
  logic        tc_start;
  logic        abort = 1'b0;
  logic [1:0]  frame_done;
  logic        timeout_err;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [1:0]  exp_src_q[$];
  logic [1:0]  got_src_q[$];
  logic [1:0]  fd_q[$];
  int hs_cnt = 0, done_cnt = -1, done_delay = 5, tmo_cnt = 0;
  int stall_word = -1, stall_left = 0;
  bit done_en = 1'b1;

  tc_frame_scheduler dut (
    .sysclk(sysclk), .reset(reset), .req(req), .gnt(gnt), .rd_addr(rd_addr),
    .rd_data(rd_data), .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_done(ser_done), .tc_start(tc_start), .abort(abort), .frame_done(frame_done),
    .timeout_err(timeout_err), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 sysclk = ~sysclk;

  assign rd_data = {32'h2000_0000 | {28'd0, rd_addr}, 32'h1000_0000 | {28'd0, rd_addr}};

  // One clock step; inputs change and outputs are read 1 time unit after the rising edge.
  task automatic cycle();
    if (ser_valid === 1'b1 && ser_ready && !abort) begin
      got_q.push_back(ser_data);
      got_src_q.push_back(gnt);
      hs_cnt++;
      if (hs_cnt == WPF) begin
        hs_cnt = 0;
        if (done_en) done_cnt = done_delay;
      end
    end
    @(posedge sysclk);
    #1;
    if (frame_done !== 2'b00) fd_q.push_back(frame_done);
    if (timeout_err === 1'b1) tmo_cnt++;
    if (done_cnt == 0) begin
      ser_done = 1'b1;
      done_cnt = -1;
    end else begin
      ser_done = 1'b0;
      if (done_cnt > 0) done_cnt--;
    end
    if (stall_left > 0 && hs_cnt == stall_word && ser_valid === 1'b1) begin
      ser_ready = 1'b0;
      stall_left--;
    end else begin
      ser_ready = 1'b1;
    end
  endtask

  task automatic clear_model();
    exp_q.delete(); got_q.delete(); exp_src_q.delete(); got_src_q.delete(); fd_q.delete();
    hs_cnt = 0; done_cnt = -1; tmo_cnt = 0;
  endtask

  task automatic push_frame(input int src, input int first, input int last);
    for (int w = first; w <= last; w++) begin
      exp_q.push_back((src == 0 ? 32'h1000_0000 : 32'h2000_0000) | 32'(w));
      exp_src_q.push_back(2'(1 << src));
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output int n);
    n = 0;
    while (dbg_state !== st && n < budget) begin cycle(); n++; end
    if (dbg_state !== st) n = -1;
  endtask

  task automatic wait_fd(input int cnt, input int budget, output int n);
    n = 0;
    while (fd_q.size() < cnt && n < budget) begin cycle(); n++; end
    if (fd_q.size() < cnt) n = -1;
  endtask

  task automatic do_reset();
    req = '0; abort = 1'b0; reset = 1'b0;
    @(posedge sysclk); #1;
    reset = 1'b1;
    clear_model();
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (gnt !== 2'b00 || tc_start !== 1'b0 || ser_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_ctrl: got gnt=%b tc_start=%b ser_valid=%b want 00 0 0", gnt, tc_start, ser_valid); end
    n_vec++; if (rd_addr !== 4'd0 || ser_data !== 32'd0) begin n_err++;
      $display("FAIL reset_data: got rd_addr=%0d ser_data=%h want 0 0", rd_addr, ser_data); end
    n_vec++; if (frame_done !== 2'b00 || timeout_err !== 1'b0 || busy !== 1'b0 || dbg_state !== S_IDLE) begin n_err++;
      $display("FAIL reset_status: got fd=%b to=%b busy=%b st=%0d want 00 0 0 0", frame_done, timeout_err, busy, dbg_state); end
    @(posedge sysclk); #1;
    reset = 1'b1;
    cycle();
    n_vec++; if (dbg_state !== S_IDLE || busy !== 1'b0) begin n_err++;
      $display("FAIL reset_idle: got st=%0d busy=%b want 0 0", dbg_state, busy); end
  endtask

  task automatic test_single();
    int n;
    bit tc_ok;
    clear_model();
    push_frame(0, 0, 9);
    req = 2'b01;
    cycle();
    n_vec++; if (dbg_state !== S_ARB || gnt !== 2'b00 || tc_start !== 1'b0) begin n_err++;
      $display("FAIL single_arb: got st=%0d gnt=%b tc=%b want 1 00 0", dbg_state, gnt, tc_start); end
    cycle();
    n_vec++; if (gnt !== 2'b01 || tc_start !== 1'b1 || ser_valid !== 1'b0 || rd_addr !== 4'd0) begin n_err++;
      $display("FAIL single_grant: got gnt=%b tc=%b v=%b addr=%0d want 01 1 0 0", gnt, tc_start, ser_valid, rd_addr); end
    cycle();
    n_vec++; if (ser_valid !== 1'b1 || ser_data !== 32'h1000_0000) begin n_err++;
      $display("FAIL single_first_word: got v=%b data=%h want 1 10000000", ser_valid, ser_data); end
    req = 2'b00;
    tc_ok = 1'b1; n = 0;
    while (fd_q.size() == 0 && n < 200) begin
      if (tc_start !== 1'b1) tc_ok = 1'b0;
      cycle(); n++;
    end
    n_vec++; if (tc_ok !== 1'b1) begin n_err++;
      $display("FAIL single_tc_hold: got tc_start dropped before ser_done, want held"); end
    n_vec++; if (fd_q.size() != 1 || fd_q[0] !== 2'b01) begin n_err++;
      $display("FAIL single_frame_done: got %0d pulses want one pulse of 01", fd_q.size()); end
    n_vec++; if (tc_start !== 1'b0 || gnt !== 2'b00 || dbg_state !== S_GAP) begin n_err++;
      $display("FAIL single_drain_exit: got tc=%b gnt=%b st=%0d want 0 00 5", tc_start, gnt, dbg_state); end
    wait_state(S_IDLE, 200, n);
    n_vec++; if (n != 64 || busy !== 1'b0) begin n_err++;
      $display("FAIL single_gap: got %0d cycles busy=%b want 64 0", n, busy); end
    n_vec++; if (fd_q.size() != 1) begin n_err++;
      $display("FAIL single_fd_width: got %0d cycles of frame_done want 1", fd_q.size()); end
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++;
      $display("FAIL single_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++;
        $display("FAIL single_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall_regrant();
    int n, lows;
    clear_model();
    push_frame(0, 0, 9);
    stall_word = 3; stall_left = 20;
    req = 2'b01;
    cycle(); cycle();
    n_vec++; if (gnt !== 2'b01) begin n_err++;
      $display("FAIL regrant_src0: got gnt=%b want 01", gnt); end
    req = 2'b00;
    n = 0; lows = 0;
    while (fd_q.size() == 0 && n < 300) begin
      cycle(); n++;
      if (ser_ready === 1'b0) begin
        lows++;
        n_vec++; if (ser_valid !== 1'b1 || ser_data !== 32'h1000_0003) begin n_err++;
          $display("FAIL stall_hold: got v=%b data=%h want 1 10000003", ser_valid, ser_data); end
      end
    end
    stall_word = -1;
    n_vec++; if (lows != 20 || fd_q.size() != 1) begin n_err++;
      $display("FAIL stall_done: got %0d stall cycles %0d frame_done want 20 1", lows, fd_q.size()); end
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++;
      $display("FAIL stall_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++;
        $display("FAIL stall_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    wait_state(S_IDLE, 200, n);
  endtask

  task automatic test_alternate();
    int n;
    do_reset();
    done_delay = 2;
    for (int f = 0; f < 4; f++) push_frame(f % 2, 0, 9);
    req = 2'b11;
    wait_fd(4, 1200, n);
    req = 2'b00;
    n_vec++; if (n < 0) begin n_err++;
      $display("FAIL alt_frames: got %0d frames want 4", fd_q.size()); end
    for (int i = 0; i < 4 && i < fd_q.size(); i++) begin
      n_vec++; if (fd_q[i] !== 2'(1 << (i % 2))) begin n_err++;
        $display("FAIL alt_order%0d: got frame_done=%b want %b", i, fd_q[i], 2'(1 << (i % 2))); end
    end
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++;
      $display("FAIL alt_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i] || got_src_q[i] !== exp_src_q[i]) begin n_err++;
        $display("FAIL alt_word%0d: got %h gnt=%b want %h gnt=%b", i, got_q[i], got_src_q[i], exp_q[i], exp_src_q[i]); end
    end
    wait_state(S_IDLE, 200, n);
    done_delay = 5;
  endtask

  task automatic test_abort();
    int n;
    clear_model();
    push_frame(0, 0, 4);
    push_frame(0, 0, 9);
    req = 2'b01;
    n = 0;
    while (!(hs_cnt == 5 && ser_valid === 1'b1) && n < 100) begin cycle(); n++; end
    n_vec++; if (dbg_state !== S_PUSH || ser_data !== 32'h1000_0005) begin n_err++;
      $display("FAIL abort_reach: got st=%0d data=%h want 3 10000005", dbg_state, ser_data); end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    hs_cnt = 0;
    n_vec++; if (tc_start !== 1'b0 || gnt !== 2'b00 || ser_valid !== 1'b0 || dbg_state !== S_GAP) begin n_err++;
      $display("FAIL abort_teardown: got tc=%b gnt=%b v=%b st=%0d want 0 00 0 5", tc_start, gnt, ser_valid, dbg_state); end
    wait_state(S_IDLE, 200, n);
    n_vec++; if (n != 64 || fd_q.size() != 0) begin n_err++;
      $display("FAIL abort_gap: got %0d cycles %0d frame_done want 64 0", n, fd_q.size()); end
    cycle(); cycle();
    n_vec++; if (gnt !== 2'b01 || tc_start !== 1'b1) begin n_err++;
      $display("FAIL abort_rearb: got gnt=%b tc=%b want 01 1", gnt, tc_start); end
    req = 2'b00;
    wait_fd(1, 300, n);
    n_vec++; if (n < 0 || fd_q[0] !== 2'b01) begin n_err++;
      $display("FAIL abort_next_frame: got %0d frame_done want one of 01", fd_q.size()); end
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++;
      $display("FAIL abort_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++;
        $display("FAIL abort_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    wait_state(S_IDLE, 200, n);
  endtask

  task automatic test_timeout();
    int n;
    clear_model();
    done_en = 1'b0;
    req = 2'b01;
    cycle(); cycle();
    req = 2'b00;
    wait_state(S_DRAIN, 100, n);
    n = 0;
    while (timeout_err !== 1'b1 && n < 5000) begin cycle(); n++; end
    n_vec++; if (n != 4096) begin n_err++;
      $display("FAIL timeout_latency: got %0d cycles want 4096", n); end
    n_vec++; if (dbg_state !== S_GAP || tc_start !== 1'b0 || gnt !== 2'b00) begin n_err++;
      $display("FAIL timeout_teardown: got st=%0d tc=%b gnt=%b want 5 0 00", dbg_state, tc_start, gnt); end
    wait_state(S_IDLE, 200, n);
    n_vec++; if (n != 64 || busy !== 1'b0 || tmo_cnt != 1 || fd_q.size() != 0) begin n_err++;
      $display("FAIL timeout_recover: got gap=%0d busy=%b pulses=%0d fd=%0d want 64 0 1 0", n, busy, tmo_cnt, fd_q.size()); end
    done_en = 1'b1;
    clear_model();
    push_frame(0, 0, 9);
    req = 2'b01;
    cycle(); cycle();
    req = 2'b00;
    wait_fd(1, 300, n);
    n_vec++; if (n < 0 || fd_q[0] !== 2'b01 || got_q.size() != exp_q.size()) begin n_err++;
      $display("FAIL timeout_next_frame: got fd=%0d words=%0d want 1 10", fd_q.size(), got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++;
        $display("FAIL timeout_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    wait_state(S_IDLE, 200, n);
  endtask

  task automatic test_reset_mid();
    int n;
    clear_model();
    req = 2'b01;
    repeat (6) cycle();
    #2;
    reset = 1'b0;
    #1;
    n_vec++; if (gnt !== 2'b00 || tc_start !== 1'b0 || ser_valid !== 1'b0 || rd_addr !== 4'd0 || busy !== 1'b0) begin n_err++;
      $display("FAIL midreset_async: got gnt=%b tc=%b v=%b addr=%0d busy=%b want 00 0 0 0 0", gnt, tc_start, ser_valid, rd_addr, busy); end
    req = 2'b10;
    @(posedge sysclk); #1;
    reset = 1'b1;
    clear_model();
    push_frame(1, 0, 9);
    cycle(); cycle();
    n_vec++; if (gnt !== 2'b10 || tc_start !== 1'b1) begin n_err++;
      $display("FAIL midreset_src1: got gnt=%b tc=%b want 10 1", gnt, tc_start); end
    req = 2'b00;
    wait_fd(1, 300, n);
    n_vec++; if (n < 0 || fd_q[0] !== 2'b10 || got_q.size() != exp_q.size()) begin n_err++;
      $display("FAIL midreset_frame: got fd=%0d words=%0d want 1 10", fd_q.size(), got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++;
        $display("FAIL midreset_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    wait_state(S_IDLE, 200, n);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_regrant();
    test_alternate();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1, "time limit");
  end

endmodule
